// File: rtl/fifo_readout_seq.sv
// fifo_readout_seq
//   Read-side sequencer for the octal capture storage. When the host issues a start, the block
//   drains num_samples words from one channel FIFO using a one-hot rden. Read data comes back
//   on din a fixed RD_LAT cycles later. It is pushed into a small skid FIFO and presented as
//   OUT_W-bit words on a valid/ready stream.
//   A read is issued only when the skid has room for the reads already in flight, so
//   back-pressure never loses a sample.
//
// Build option (macro CHAN_TAG_EN):
//   defined   : dout[15:13] = channel of the word, dout[12] = last-word flag
//   undefined : upper dout bits are zero
//
// Ports:
//   i_rdclk         read-domain clock, all logic on posedge
//   i_rst           synchronous active-high reset
//   i_start         single-cycle request, sampled only in IDLE
//   i_chan          channel select, latched on accepted start
//   i_num_samples   samples to read, latched on accepted start
//   i_abort         cancel current transfer (wins over start)
//   o_busy          high from accepted start until return to IDLE
//   o_done          one-cycle pulse after the last word is accepted
//   o_rden          one-hot FIFO read enable, zero when not issuing
//   i_din           registered sample from storage, RD_LAT after rden
//   o_dout          host word
//   o_dout_valid    o_dout holds a word
//   i_dout_ready    host accepts the word when valid && ready
module fifo_readout_seq #(
  parameter int DATA_W     = 12,
  parameter int OUT_W      = 16,
  parameter int CNT_W      = 16,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic              i_rdclk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_chan,
  input  logic [CNT_W-1:0]  i_num_samples,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_rden,
  input  logic [DATA_W-1:0] i_din,
  output logic [OUT_W-1:0]  o_dout,
  output logic              o_dout_valid,
  input  logic              i_dout_ready
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            r_state;
  logic [2:0]        r_chan;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_iss_cnt;
  logic [CNT_W-1:0]  r_ret_cnt;
  logic [RD_LAT-1:0] r_vld_pipe;
  // Each skid entry is {last-word flag, sample}.
  logic [DATA_W:0]   r_mem [SKID_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_busy;
  logic              r_done;

  logic [CW-1:0]     w_inflight;
  logic              w_space;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_last_in;
  logic [DATA_W:0]   w_head;

  // Count the reads issued in the last RD_LAT cycles. The tail bit is included even though
  // it lands in the skid this cycle, so the space test stays conservative.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_vld_pipe[i]);
  end

  assign w_space   = ({1'b0, r_count} + {1'b0, w_inflight}) < (CW+1)'(SKID_DEPTH);
  // rden is combinational so that abort can kill it in the same cycle.
  assign w_issue   = !i_rst && !i_abort && (r_state == S_ISSUE) &&
                     (r_iss_cnt != r_num) && w_space;
  assign o_rden    = w_issue ? (8'd1 << r_chan) : 8'd0;
  assign w_push    = r_vld_pipe[RD_LAT-1];
  assign o_dout_valid = (r_count != '0);
  assign w_pop     = o_dout_valid && i_dout_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_last_in = (r_ret_cnt == r_num - 1'b1);
  assign o_busy    = r_busy;
  assign o_done    = r_done;

`ifdef CHAN_TAG_EN
  assign o_dout = o_dout_valid ? OUT_W'({r_chan, w_head}) : '0;
`else
  assign o_dout = o_dout_valid ? OUT_W'(w_head[DATA_W-1:0]) : '0;
`endif

  always_ff @(posedge i_rdclk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_chan     <= '0;
      r_num      <= '0;
      r_iss_cnt  <= '0;
      r_ret_cnt  <= '0;
      r_vld_pipe <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_vld_pipe <= (r_vld_pipe << 1) | RD_LAT'(w_issue);
      if (w_issue) r_iss_cnt <= r_iss_cnt + 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_last_in, i_din};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_ret_cnt       <= r_ret_cnt + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_chan    <= i_chan;
            r_num     <= i_num_samples;
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_busy    <= 1'b1;
            // An empty request completes at once: busy and done are both high for one cycle.
            if (i_num_samples == '0) begin
              r_state <= S_DRAIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue && (r_iss_cnt == r_num - 1'b1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_num == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_pop && w_head[DATA_W]) begin
            // The head is the last word and it is handshaken now, so no reads remain in
            // flight and the skid holds nothing else.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (i_abort) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
        r_vld_pipe <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_readout_seq.sv
// Bench for fifo_readout_seq: storage model + scoreboard, table of transfers, hand sequences
// for empty request, abort, reset mid-transfer and the tag/data mapping.
module tb_fifo_readout_seq;
  localparam int DATA_W = 12, OUT_W = 16, CNT_W = 16, RD_LAT = 2, SKID_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst, start, abort, ready;
  logic [2:0]        chan;
  logic [CNT_W-1:0]  num;
  logic              busy, done, dv;
  logic [7:0]        rden;
  logic [DATA_W-1:0] din;
  logic [OUT_W-1:0]  dout;

  always #5 clk = ~clk;

  fifo_readout_seq #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT),
                     .SKID_DEPTH(SKID_DEPTH)) dut (
    .i_rdclk(clk), .i_rst(rst), .i_start(start), .i_chan(chan), .i_num_samples(num),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_rden(rden), .i_din(din),
    .o_dout(dout), .o_dout_valid(dv), .i_dout_ready(ready));

  int nchk = 0, nerr = 0;
  logic [OUT_W-1:0]  sb[$];
  logic [OUT_W-1:0]  wlog[$];
  logic [DATA_W-1:0] ovr_q[$];
  logic [2:0]        cur_chan = 3'd0;
  int                cur_n = 0, xfer_base = 0, iss0 = 0, acc0 = 0;
  int                iss_tot = 0, acc_tot = 0, done_cnt = 0;
  bit                chk_out = 1'b0;
  logic [DATA_W-1:0] rd_v = '0, st1 = '0, mv;
  logic [OUT_W-1:0]  prev_dout = '0;
  bit                prev_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Storage register pipeline: a read seen in cycle t appears on din during cycle t+RD_LAT.
  always @(posedge clk) begin
    st1 <= rd_v;
    din <= st1;
  end

  // Mid-cycle monitor: host-side checks first, then the read bookkeeping for this cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dv && prev_stall) chk("hold_stable", dout, prev_dout);
    if (chk_out && busy)
      chk("outstanding_le_depth", 32'((iss_tot - iss0) - (acc_tot - acc0) <= SKID_DEPTH), 1);
    if (dv && ready) begin
      if (sb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_word: got %0h, expected no word", dout);
      end else chk("word", dout, sb.pop_front());
      wlog.push_back(dout);
      acc_tot++;
    end
    prev_stall = dv && !ready;
    prev_dout  = dout;
    if (rden != 8'd0) begin
      chk("rden_onehot", rden, 8'd1 << cur_chan);
      mv = (ovr_q.size() > 0) ? ovr_q.pop_front() : DATA_W'($urandom);
`ifdef CHAN_TAG_EN
      sb.push_back({cur_chan, (iss_tot - xfer_base) == cur_n - 1, mv});
`else
      sb.push_back({4'h0, mv});
`endif
      rd_v = mv;
      iss_tot++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic run_xfer(input logic [2:0] ch, input int n, input int mode, input int exp_w,
                          input int exp_d, input string nm);
    int d0;
    bit got;
    d0 = done_cnt; iss0 = iss_tot; acc0 = acc_tot; xfer_base = iss_tot;
    cur_chan = ch; cur_n = n;
    chan = ch; num = CNT_W'(n); start = 1'b1; ready = 1'b1; chk_out = 1'b1;
    cyc(); start = 1'b0;
    chk({nm, "_busy_start"}, busy, 1);
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      cyc();
      if (done_cnt != d0) got = 1'b1;
    end
    if (!got) begin
      nchk++; nerr++;
      $display("FAIL %s_timeout: got no done, expected done within 400 cycles", nm);
    end
    ready = 1'b1;
    repeat (4) cyc();
    chk_out = 1'b0;
    chk({nm, "_words"}, acc_tot - acc0, exp_w);
    chk({nm, "_rden_cycles"}, iss_tot - iss0, exp_w);
    chk({nm, "_done_pulses"}, done_cnt - d0, exp_d);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  typedef struct {
    logic [2:0] ch;
    int         n;
    int         mode;       // 0 ready high, 1 toggle, 2 random
    int         exp_words;
    int         exp_done;
  } vec_t;
  vec_t vecs[5];

  logic [OUT_W-1:0] exp_t0, exp_t1;
  int d0, i0, w0;
  bit got;

  initial begin
    vecs[0] = '{3'd3, 5,  0, 5,  1};
    vecs[1] = '{3'd0, 8,  1, 8,  1};
    vecs[2] = '{3'd7, 1,  2, 1,  1};
    vecs[3] = '{3'd1, 12, 2, 12, 1};
    vecs[4] = '{3'd4, 9,  1, 9,  1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; chan = '0; num = '0;
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", rden, 0);
    chk("rst_valid", dv, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;
    cyc();

    foreach (vecs[t])
      run_xfer(vecs[t].ch, vecs[t].n, vecs[t].mode, vecs[t].exp_words, vecs[t].exp_done,
               $sformatf("vec%0d", t));

    // Empty request: busy and done high together for exactly the cycle after start.
    d0 = done_cnt; i0 = iss_tot; w0 = acc_tot;
    chan = 3'd2; num = '0; start = 1'b1; ready = 1'b1;
    cyc(); start = 1'b0;
    chk("n0_busy", busy, 1);
    chk("n0_done", done, 1);
    chk("n0_rden", rden, 0);
    cyc();
    chk("n0_busy_drop", busy, 0);
    chk("n0_done_drop", done, 0);
    repeat (3) cyc();
    chk("n0_no_reads", iss_tot - i0, 0);
    chk("n0_no_words", acc_tot - w0, 0);
    chk("n0_done_once", done_cnt - d0, 1);

    // Abort after three accepted words; a second start while busy must be ignored.
    d0 = done_cnt; w0 = acc_tot; xfer_base = iss_tot; cur_chan = 3'd2; cur_n = 10;
    chan = 3'd2; num = 16'd10; start = 1'b1; ready = 1'b1;
    cyc();
    chan = 3'd5; num = 16'd3;
    cyc(); start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (acc_tot - w0 >= 3) got = 1'b1;
      else cyc();
    end
    chk("abort_reached_3", 32'(got), 1);
    ready = 1'b0; abort = 1'b1;
    #1 chk("abort_rden_same_cycle", rden, 0);
    cyc(); abort = 1'b0;
    chk("abort_valid_next", dv, 0);
    chk("abort_busy_next", busy, 0);
    sb.delete();
    ready = 1'b1;
    repeat (10) cyc();
    chk("abort_words", acc_tot - w0, 3);
    chk("abort_no_done", done_cnt - d0, 0);

    // Reset in the middle of issuing with the host stalled.
    xfer_base = iss_tot; cur_chan = 3'd5; cur_n = 20;
    chan = 3'd5; num = 16'd20; start = 1'b1; ready = 1'b0;
    cyc(); start = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_rden", rden, 0);
    chk("mrst_valid", dv, 0);
    chk("mrst_dout", dout, 0);
    rst = 1'b0;
    sb.delete();
    cyc();
    run_xfer(3'd1, 4, 0, 4, 1, "post_rst");

    // Data mapping with known samples.
`ifdef CHAN_TAG_EN
    exp_t0 = 16'hCABC; exp_t1 = 16'hD123;
`else
    exp_t0 = 16'h0ABC; exp_t1 = 16'h0123;
`endif
    ovr_q.push_back(12'hABC); ovr_q.push_back(12'h123);
    wlog.delete();
    run_xfer(3'd6, 2, 0, 2, 1, "tag");
    chk("tag_count", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("tag_word0", wlog[0], exp_t0);
      chk("tag_word1", wlog[1], exp_t1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000 time units");
    $fatal(1);
  end

endmodule
